// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock, MSB first
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   rst_n       - synchronous active-low reset
//   start       - begin a division (sampled only in IDLE)
//   a, b        - unsigned dividend / divisor, latched on the accepting edge
//   busy        - high while in CALC
//   done        - one-cycle pulse; q, r, div_by_zero valid while high
//   q, r        - registered quotient / remainder, held until the next result
//   div_by_zero - high with done when the latched divisor was 0
module seq_divider #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] r,
    output logic            div_by_zero
);
    localparam int CW = $clog2(SIZE);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state, state_nx;
    logic [SIZE-1:0] dvd, dvs, rem, rem_nx;
    logic [SIZE:0]   rem_sh;
    logic [CW-1:0]   cnt;
    logic            ge, last;
    // dvd shifts the dividend out at the top while quotient bits enter at the bottom,
    // so after SIZE steps it holds the quotient
    always_comb begin
        rem_sh = {rem, dvd[SIZE-1]};
        ge     = rem_sh >= {1'b0, dvs};
        rem_nx = ge ? SIZE'(rem_sh - {1'b0, dvs}) : rem_sh[SIZE-1:0];
        last   = cnt == CW'(SIZE - 1);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (b == '0 ? DONE : CALC) : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && b == '0) begin
                        q           <= '1;
                        r           <= a;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        dvd <= a;
                        dvs <= b;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    dvd <= {dvd[SIZE-2:0], ge};
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        q           <= {dvd[SIZE-2:0], ge};
                        r           <= rem_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
    assign busy = state == CALC;
    assign done = state == DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table plus corner sequences and an a/b sweep for seq_divider (SIZE=8)
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst_n, start, busy, done, div_by_zero;
    logic [7:0] a, b, q, r;
    int         checks = 0, failures = 0, done_cnt = 0, exp_dones = 0;

    seq_divider #(.SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dbz;
        int         lat;
    } vec_t;
    vec_t vecs[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one start pulse; reports latency in edges after T, busy cycles, overlap and a stretched done
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] oq, output logic [7:0] orr, output logic odbz,
                          output int lat, output int nbusy, output logic ovl, output logic dbl);
        a = ia; b = ib; start = 1'b1;
        tick;
        start = 1'b0;
        exp_dones++;
        lat = 0; nbusy = 0; ovl = 1'b0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            tick;
            lat++;
        end
        ovl = busy && done;
        oq = q; orr = r; odbz = div_by_zero;
        tick;
        dbl = done;
    endtask

    logic [7:0] oq, orr;
    logic       odbz, ovl, dbl;
    int         lat, nbusy, n;

    initial begin
        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 8};
        vecs[3] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 0};
        vecs[4] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0, 8};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8};
        vecs[8] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
        vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0};

        rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) tick;
        check("reset_outputs", {busy, done, div_by_zero, q, r}, 0);
        rst_n = 1'b1;
        tick;
        check("idle_after_reset", {busy, done}, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, oq, orr, odbz, lat, nbusy, ovl, dbl);
            check($sformatf("vec%0d_q", i), oq, vecs[i].q);
            check($sformatf("vec%0d_r", i), orr, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), odbz, vecs[i].dbz);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].lat);
            check($sformatf("vec%0d_busy_done_overlap", i), ovl, 0);
            check($sformatf("vec%0d_done_width", i), dbl, 0);
        end

        // outputs hold in IDLE while a/b wander
        a = 8'd9; b = 8'd3;
        repeat (5) tick;
        check("hold_q", q, 8'hFF);
        check("hold_r", r, 8'd0);
        check("hold_dbz", div_by_zero, 1);

        // back to back with start held high throughout
        a = 8'd255; b = 8'd1; start = 1'b1;
        tick;
        n = 0;
        while (!done && n < 40) begin tick; n++; end
        check("b2b_first_latency", n, 8);
        check("b2b_first_q", q, 255);
        check("b2b_first_r", r, 0);
        a = 8'd3; b = 8'd10;
        n = 0;
        tick; n++;
        while (!done && n < 40) begin tick; n++; end
        check("b2b_gap_edges", n, 10);
        check("b2b_second_q", q, 0);
        check("b2b_second_r", r, 3);
        start = 1'b0;
        exp_dones += 2;
        tick;
        check("b2b_done_drops", done, 0);

        // operand changes and a start pulse mid-CALC are ignored
        a = 8'd200; b = 8'd9; start = 1'b1;
        tick;
        start = 1'b0;
        exp_dones++;
        repeat (3) tick;
        a = 8'd1; b = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        n = 4;
        while (!done && n < 40) begin tick; n++; end
        check("ignore_start_latency", n, 8);
        check("ignore_start_q", q, 22);
        check("ignore_start_r", r, 2);
        repeat (12) tick;
        check("ignore_start_no_second_done", done_cnt, exp_dones);

        // reset at CALC step 4 aborts without a done pulse
        a = 8'd100; b = 8'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        check("abort_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_outputs_cleared", {busy, done, div_by_zero, q, r}, 0);
        repeat (15) tick;
        check("abort_no_done", done_cnt, exp_dones);
        check("abort_stays_idle", busy, 0);
        run_op(8'd100, 8'd7, oq, orr, odbz, lat, nbusy, ovl, dbl);
        check("after_abort_q", oq, 14);
        check("after_abort_r", orr, 2);
        check("after_abort_latency", lat, 8);

        // sweep checked against a == q*b + r, r < b, and the divide-by-zero convention
        for (int ia = 0; ia < 256; ia += 5) begin
            for (int ib = 0; ib < 256; ib += 7) begin
                run_op(8'(ia), 8'(ib), oq, orr, odbz, lat, nbusy, ovl, dbl);
                checks++;
                if (ib != 0 ? (int'(oq) * ib + int'(orr) != ia || int'(orr) >= ib || oq != 8'(ia / ib)
                               || odbz || lat != 8)
                            : (oq != 8'hFF || orr != 8'(ia) || !odbz || lat != 0)
                    || ovl || dbl) begin
                    failures++;
                    $display("FAIL sweep a=%0d b=%0d: got q=%0d r=%0d dbz=%0d lat=%0d", ia, ib, oq, orr, odbz, lat);
                end
            end
        end
        tick;
        check("done_once_per_start", done_cnt, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
